// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl
// Multi-cycle unsigned multiply (shift-add) and restoring divide.
// Each step does one add/subtract and one shift. The core issues a request
// with i_start and waits for o_done.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_start      request, sampled only in IDLE
//   i_op         0 = multiply, 1 = divide (captured with i_start)
//   i_a          multiplicand / dividend (captured with i_start)
//   i_b          multiplier / divisor (captured with i_start)
//   o_busy       high from the accepting edge through the DONE cycle
//   o_done       one-cycle pulse; results are valid from this cycle on
//   o_res_hi     MUL: product[2W-1:W]   DIV: remainder
//   o_res_lo     MUL: product[W-1:0]    DIV: quotient
//   o_div_zero   set with done for a divide by zero; cleared on next accept
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for i_start; results hold their last values
// STEP   | one shift-add / shift-subtract iteration per cycle
// DONE   | o_done pulse, results valid; returns to IDLE

module muldiv_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_res_hi,
   output logic [WIDTH-1:0] o_res_lo,
   output logic             o_div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_STEP = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_op;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_div_zero;

   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_rem;
   logic [WIDTH:0]   w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_hi;

   // Multiply: carry of the add becomes the new MSB after the right shift.
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

   // Divide: the left-shifted remainder is WIDTH+1 bits wide. Whenever its
   // top bit is set it is >= b, so the kept value always fits WIDTH bits.
   assign w_div_rem  = {r_hi, r_lo[WIDTH-1]};
   assign w_div_ge   = (w_div_rem >= {1'b0, r_b});
   assign w_div_diff = w_div_rem - {1'b0, r_b};
   assign w_div_hi   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem[WIDTH-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= 1'b0;
         r_b        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_op       <= i_op;
                  r_b        <= i_b;
                  r_cnt      <= '0;
                  r_div_zero <= 1'b0;
                  if (i_op && (i_b == '0)) begin
                     r_hi       <= i_a;
                     r_lo       <= '1;
                     r_div_zero <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_hi    <= '0;
                     r_lo    <= i_a;
                     r_state <= S_STEP;
                  end
               end
            end
            S_STEP: begin
               r_cnt <= r_cnt + CNT_ONE;
               if (r_op) begin
                  r_hi <= w_div_hi;
                  r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
               end else begin
                  {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
               end
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = (r_state == S_DONE);
   assign o_res_hi   = r_hi;
   assign o_res_lo   = r_lo;
   assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: multiply, divide, divide-by-zero,
// start-while-busy and asynchronous reset mid-operation.

module tb_muldiv_seq_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_start;
   logic       i_op;
   logic [7:0] i_a;
   logic [7:0] i_b;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_res_hi;
   logic [7:0] o_res_lo;
   logic       o_div_zero;

   int n_vec = 0;
   int n_err = 0;

   muldiv_seq_ctrl #(.WIDTH(8)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_op       (i_op),
      .i_a        (i_a),
      .i_b        (i_b),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_res_hi   (o_res_hi),
      .o_res_lo   (o_res_lo),
      .o_div_zero (o_div_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request and waits (bounded) for done. edges counts rising
   // edges from the accepting edge (inclusive) to the first cycle with done.
   task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                         output int edges, output int busy_cyc, output logic dz_accept);
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      @(posedge i_clk);
      edges    = 1;
      busy_cyc = 0;
      #1 i_start = 1'b0;
      @(negedge i_clk);
      dz_accept = o_div_zero;
      while (!o_done && edges < 40) begin
         if (o_busy) busy_cyc++;
         @(posedge i_clk);
         edges++;
         @(negedge i_clk);
      end
      if (o_busy) busy_cyc++;
   endtask

   int   edges, busy_cyc, dones;
   logic dz_acc;
   logic [7:0] cap_hi, cap_lo;

   initial begin
      i_rst   = 1'b1;
      i_start = 1'b0;
      i_op    = 1'b0;
      i_a     = '0;
      i_b     = '0;
      @(negedge i_clk);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_hi", o_res_hi, 0);
      check("rst_lo", o_res_lo, 0);
      check("rst_dz", o_div_zero, 0);
      i_rst = 1'b0;

      // 13 * 11 = 143
      run_op(1'b0, 8'd13, 8'd11, edges, busy_cyc, dz_acc);
      check("mul1_edges", edges, 9);
      check("mul1_busy_cyc", busy_cyc, 9);
      check("mul1_hi", o_res_hi, 8'h00);
      check("mul1_lo", o_res_lo, 8'h8F);
      check("mul1_dz", o_div_zero, 0);
      @(negedge i_clk);
      check("mul1_done_pulse", o_done, 0);
      check("mul1_idle", o_busy, 0);
      check("mul1_hold_lo", o_res_lo, 8'h8F);

      // 255 * 255 = 65025 = 0xFE01
      run_op(1'b0, 8'd255, 8'd255, edges, busy_cyc, dz_acc);
      check("mul2_edges", edges, 9);
      check("mul2_hi", o_res_hi, 8'hFE);
      check("mul2_lo", o_res_lo, 8'h01);

      // 200 / 7 = 28 r 4
      run_op(1'b1, 8'd200, 8'd7, edges, busy_cyc, dz_acc);
      check("div1_edges", edges, 9);
      check("div1_q", o_res_lo, 8'h1C);
      check("div1_r", o_res_hi, 8'h04);
      check("div1_dz", o_div_zero, 0);

      // 5 / 9 = 0 r 5
      run_op(1'b1, 8'd5, 8'd9, edges, busy_cyc, dz_acc);
      check("div2_q", o_res_lo, 8'h00);
      check("div2_r", o_res_hi, 8'h05);

      // 255 / 16 = 15 r 15
      run_op(1'b1, 8'd255, 8'd16, edges, busy_cyc, dz_acc);
      check("div3_q", o_res_lo, 8'h0F);
      check("div3_r", o_res_hi, 8'h0F);

      // 0x5A / 0: one edge to done
      run_op(1'b1, 8'h5A, 8'h00, edges, busy_cyc, dz_acc);
      check("dz_edges", edges, 1);
      check("dz_flag", o_div_zero, 1);
      check("dz_lo", o_res_lo, 8'hFF);
      check("dz_hi", o_res_hi, 8'h5A);
      check("dz_busy", o_busy, 1);
      @(negedge i_clk);
      check("dz_hold_flag", o_div_zero, 1);
      check("dz_done_pulse", o_done, 0);

      // next accept clears div_zero; 2 * 3 = 6
      run_op(1'b0, 8'd2, 8'd3, edges, busy_cyc, dz_acc);
      check("dz_clear_accept", dz_acc, 0);
      check("mul3_lo", o_res_lo, 8'h06);
      check("mul3_hi", o_res_hi, 8'h00);

      // 3 * 4 with a divide-by-zero request injected during STEP
      @(negedge i_clk);
      i_start = 1'b1; i_op = 1'b0; i_a = 8'd3; i_b = 8'd4;
      @(negedge i_clk);
      i_start = 1'b0;
      dones  = 0;
      cap_hi = '0;
      cap_lo = '0;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) begin
            i_start = 1'b1; i_op = 1'b1; i_a = 8'd99; i_b = 8'd0;
         end else if (i == 3) begin
            i_start = 1'b0;
         end
         if (o_done) begin
            dones++;
            cap_hi = o_res_hi;
            cap_lo = o_res_lo;
         end
         @(negedge i_clk);
      end
      check("ign_dones", dones, 1);
      check("ign_lo", cap_lo, 8'd12);
      check("ign_hi", cap_hi, 8'd0);
      check("ign_dz", o_div_zero, 0);

      // async reset mid-STEP during 5 * 6
      @(negedge i_clk);
      i_start = 1'b1; i_op = 1'b0; i_a = 8'd5; i_b = 8'd6;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      repeat (3) @(posedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      check("arst_busy", o_busy, 0);
      check("arst_done", o_done, 0);
      check("arst_hi", o_res_hi, 0);
      check("arst_lo", o_res_lo, 0);
      check("arst_dz", o_div_zero, 0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge i_clk);
         if (o_done) dones++;
         if (i == 2) i_rst = 1'b0;
      end
      check("arst_no_done", dones, 0);

      // 7 * 9 = 63
      run_op(1'b0, 8'd7, 8'd9, edges, busy_cyc, dz_acc);
      check("mul4_edges", edges, 9);
      check("mul4_lo", o_res_lo, 8'd63);
      check("mul4_hi", o_res_hi, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
